// File: rtl/inst_fetch.sv
// Instruction fetch stage: PC register, IDLE/RUN enable FSM and the IF/ID pipeline register.
// Optional macro PC_ALIGN_CHECK_EN adds id_adel, which flags a misaligned fetch as an address error.
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] new_pc,
  input  logic        branch_flag,
  input  logic [31:0] branch_target,
  output logic        rom_ce,
  output logic [31:0] rom_addr,
  input  logic [31:0] rom_inst,
  output logic [31:0] id_pc,
  output logic [31:0] id_inst,
`ifdef PC_ALIGN_CHECK_EN
  output logic        id_adel,
`endif
  output logic        id_valid
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] id_pc_q, id_pc_d;
  logic [31:0] id_inst_q, id_inst_d;
  logic        id_valid_q, id_valid_d;
`ifdef PC_ALIGN_CHECK_EN
  logic        id_adel_q, id_adel_d;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      id_pc_q    <= 32'h0;
      id_inst_q  <= 32'h0;
      id_valid_q <= 1'b0;
`ifdef PC_ALIGN_CHECK_EN
      id_adel_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      id_pc_q    <= id_pc_d;
      id_inst_q  <= id_inst_d;
      id_valid_q <= id_valid_d;
`ifdef PC_ALIGN_CHECK_EN
      id_adel_q  <= id_adel_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    id_pc_d    = id_pc_q;
    id_inst_d  = id_inst_q;
    id_valid_d = id_valid_q;
`ifdef PC_ALIGN_CHECK_EN
    id_adel_d  = id_adel_q;
`endif
    case (state_q)
      IDLE: begin
        // The ID side stays zero while idle; only the PC may be redirected.
        state_d = RUN;
        if (flush) pc_d = new_pc;
      end
      RUN: begin
        if (flush) begin
          pc_d       = new_pc;
          id_inst_d  = 32'h0;
          id_valid_d = 1'b0;
`ifdef PC_ALIGN_CHECK_EN
          id_adel_d  = 1'b0;
`endif
        end else if (!stall) begin
          // The word at pc always goes to ID, even on a taken branch (delay slot).
          id_pc_d    = pc_q;
          id_inst_d  = rom_inst;
          id_valid_d = 1'b1;
`ifdef PC_ALIGN_CHECK_EN
          id_adel_d  = 1'b0;
          if (pc_q[1:0] != 2'b00) begin
            id_inst_d  = 32'h0;
            id_valid_d = 1'b0;
            id_adel_d  = 1'b1;
          end
`endif
          pc_d = branch_flag ? branch_target : (pc_q + 32'd4);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign rom_ce   = (state_q == RUN);
  assign rom_addr = pc_q;
  assign id_pc    = id_pc_q;
  assign id_inst  = id_inst_q;
  assign id_valid = id_valid_q;
`ifdef PC_ALIGN_CHECK_EN
  assign id_adel  = id_adel_q;
`endif

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: directed scenarios plus randomized traffic against a behavioural model.
module tb_inst_fetch;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
`ifdef PC_ALIGN_CHECK_EN
  localparam bit ALIGN_EN = 1'b1;
`else
  localparam bit ALIGN_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] new_pc = 32'h0;
  logic        branch_flag = 1'b0;
  logic [31:0] branch_target = 32'h0;
  logic        rom_ce;
  logic [31:0] rom_addr;
  logic [31:0] rom_inst;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic        id_valid;
`ifdef PC_ALIGN_CHECK_EN
  logic        id_adel;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  bit          m_run;
  logic [31:0] m_pc, m_id_pc, m_id_inst;
  logic        m_id_valid, m_adel;

  inst_fetch #(.RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .new_pc(new_pc),
    .branch_flag(branch_flag), .branch_target(branch_target),
    .rom_ce(rom_ce), .rom_addr(rom_addr), .rom_inst(rom_inst),
    .id_pc(id_pc), .id_inst(id_inst),
`ifdef PC_ALIGN_CHECK_EN
    .id_adel(id_adel),
`endif
    .id_valid(id_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return {a[1:0], a[31:2]};
  endfunction

  assign rom_inst = rom_word(rom_addr);

  function automatic string dut_str();
    return $sformatf("ce=%b addr=%h id_pc=%h id_inst=%h v=%b", rom_ce, rom_addr, id_pc, id_inst, id_valid);
  endfunction

  function automatic string mdl_str();
    return $sformatf("ce=%b addr=%h id_pc=%h id_inst=%h v=%b", m_run, m_pc, m_id_pc, m_id_inst, m_id_valid);
  endfunction

  task automatic model_reset();
    m_run = 1'b0; m_pc = RESET_PC; m_id_pc = '0; m_id_inst = '0; m_id_valid = 1'b0; m_adel = 1'b0;
  endtask

  // One clock edge as the specification describes it.
  task automatic model_step();
    if (rst) begin
      model_reset();
    end else if (!m_run) begin
      m_run = 1'b1;
      if (flush) m_pc = new_pc;
    end else if (flush) begin
      m_pc = new_pc; m_id_valid = 1'b0; m_id_inst = '0; m_adel = 1'b0;
    end else if (!stall) begin
      m_id_pc = m_pc;
      if (ALIGN_EN && m_pc[1:0] != 2'b00) begin
        m_id_inst = '0; m_id_valid = 1'b0; m_adel = 1'b1;
      end else begin
        m_id_inst = rom_word(m_pc); m_id_valid = 1'b1; m_adel = 1'b0;
      end
      m_pc = branch_flag ? branch_target : m_pc + 32'd4;
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    stall = 1'b0; flush = 1'b0; branch_flag = 1'b0;
  endtask

  task automatic test_reset();
    model_reset();
    #2;
    n_tests++;
    if ({rom_ce, rom_addr, id_pc, id_inst, id_valid} !== {1'b0, RESET_PC, 32'h0, 32'h0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_values: got %s required ce=0 addr=%h ids=0", dut_str(), RESET_PC);
    end
    tick();
    n_tests++;
    if (rom_ce !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_hold_ce: got %b required 0", rom_ce);
    end
  endtask

  task automatic test_sequential();
    logic [31:0] exp_inst [3];
    exp_inst[0] = 32'd0; exp_inst[1] = 32'd1; exp_inst[2] = 32'd2;
    idle_inputs();
    rst = 1'b0;
    tick();
    n_tests++;
    if ({rom_ce, rom_addr, id_valid} !== {1'b1, 32'h0, 1'b0}) begin
      n_fail++;
      $display("FAIL seq_first_edge: got %s required ce=1 addr=0 v=0", dut_str());
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_tests++;
      if ({id_pc, id_inst, id_valid} !== {32'(i * 4), exp_inst[i], 1'b1}) begin
        n_fail++;
        $display("FAIL seq_fetch%0d: got id_pc=%h id_inst=%h v=%b required %h %h 1", i, id_pc, id_inst, id_valid, 32'(i * 4), exp_inst[i]);
      end
    end
  endtask

  task automatic test_branch();
    logic [31:0] exp_pc [3];
    exp_pc[0] = 32'h8; exp_pc[1] = 32'h100; exp_pc[2] = 32'h104;
    idle_inputs();
    flush = 1'b1; new_pc = 32'h8;
    tick();
    flush = 1'b0; branch_flag = 1'b1; branch_target = 32'h100;
    for (int i = 0; i < 3; i++) begin
      tick();
      branch_flag = 1'b0;
      n_tests++;
      if ({id_pc, id_valid} !== {exp_pc[i], 1'b1} || id_inst !== m_id_inst) begin
        n_fail++;
        $display("FAIL branch_step%0d: got %s required id_pc=%h v=1 id_inst=%h", i, dut_str(), exp_pc[i], m_id_inst);
      end
    end
  endtask

  task automatic test_stall();
    idle_inputs();
    flush = 1'b1; new_pc = 32'h10;
    tick();
    flush = 1'b0; stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      branch_flag = (i == 1); branch_target = 32'h200;
      tick();
      n_tests++;
      if ({rom_addr, id_valid, id_inst} !== {32'h10, 1'b0, 32'h0}) begin
        n_fail++;
        $display("FAIL stall_hold%0d: got %s required addr=10 v=0 id_inst=0", i, dut_str());
      end
    end
    idle_inputs();
    tick();
    n_tests++;
    if ({rom_addr, id_pc, id_inst, id_valid} !== {32'h14, 32'h10, rom_word(32'h10), 1'b1}) begin
      n_fail++;
      $display("FAIL stall_resume: got %s required addr=14 id_pc=10 v=1", dut_str());
    end
  endtask

  task automatic test_flush();
    idle_inputs();
    tick();
    stall = 1'b1; branch_flag = 1'b1; branch_target = 32'h300; flush = 1'b1; new_pc = 32'h20;
    tick();
    n_tests++;
    if ({rom_addr, id_valid, id_inst} !== {32'h20, 1'b0, 32'h0}) begin
      n_fail++;
      $display("FAIL flush_edge: got %s required addr=20 v=0 id_inst=0", dut_str());
    end
    idle_inputs();
    tick();
    n_tests++;
    if ({id_pc, id_valid, rom_addr} !== {32'h20, 1'b1, 32'h24}) begin
      n_fail++;
      $display("FAIL flush_after: got %s required id_pc=20 v=1 addr=24", dut_str());
    end
  endtask

  task automatic test_wrap();
    idle_inputs();
    flush = 1'b1; new_pc = 32'hFFFF_FFFC;
    tick();
    flush = 1'b0;
    n_tests++;
    if (rom_addr !== 32'hFFFF_FFFC) begin
      n_fail++;
      $display("FAIL wrap_load: got addr=%h required fffffffc", rom_addr);
    end
    tick();
    n_tests++;
    if ({rom_addr, id_pc, id_valid} !== {32'h0, 32'hFFFF_FFFC, 1'b1}) begin
      n_fail++;
      $display("FAIL wrap_next: got %s required addr=0 id_pc=fffffffc v=1", dut_str());
    end
  endtask

  task automatic test_misaligned();
    idle_inputs();
    flush = 1'b1; new_pc = 32'h22;
    tick();
    flush = 1'b0;
    tick();
    n_tests++;
    if ({id_pc, id_valid} !== {32'h22, ~ALIGN_EN}) begin
      n_fail++;
      $display("FAIL misaligned: got id_pc=%h v=%b required 22 %b", id_pc, id_valid, ~ALIGN_EN);
    end
`ifdef PC_ALIGN_CHECK_EN
    n_tests++;
    if (id_adel !== 1'b1) begin
      n_fail++;
      $display("FAIL misaligned_adel: got %b required 1", id_adel);
    end
`endif
  endtask

  task automatic test_reset_mid();
    idle_inputs();
    tick();
    stall = 1'b1; flush = 1'b1; branch_flag = 1'b1; new_pc = 32'h40; branch_target = 32'h80;
    #2 rst = 1'b1;
    #1;
    model_reset();
    n_tests++;
    if ({rom_ce, rom_addr, id_pc, id_inst, id_valid} !== {1'b0, RESET_PC, 32'h0, 32'h0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_async: got %s required ce=0 addr=%h ids=0", dut_str(), RESET_PC);
    end
    tick();
    rst = 1'b0; idle_inputs();
    tick();
    n_tests++;
    if ({rom_ce, rom_addr, id_valid} !== {1'b1, RESET_PC, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_restart: got %s required ce=1 addr=%h v=0", dut_str(), RESET_PC);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      stall       = ($urandom_range(0, 3) == 0);
      flush       = ($urandom_range(0, 9) == 0);
      branch_flag = ($urandom_range(0, 4) == 0);
      new_pc        = $urandom & (($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : 32'hFFFF_FFFC);
      branch_target = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 99) == 0) begin
        #2 rst = 1'b1;
        #1 model_reset();
        tick();
        rst = 1'b0;
      end else begin
        tick();
      end
      n_tests++;
      if ({rom_ce, rom_addr, id_pc, id_inst, id_valid} !== {m_run, m_pc, m_id_pc, m_id_inst, m_id_valid}) begin
        n_fail++;
        $display("FAIL random%0d: got %s required %s", i, dut_str(), mdl_str());
      end
`ifdef PC_ALIGN_CHECK_EN
      n_tests++;
      if (id_adel !== m_adel) begin
        n_fail++;
        $display("FAIL random_adel%0d: got %b required %b", i, id_adel, m_adel);
      end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_branch();
    test_stall();
    test_flush();
    test_wrap();
    test_misaligned();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, first fetch address after reset.
REQ-002 Port: clk  in  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  in  1  asynchronous, active-high reset.
REQ-004 Port: stall  in  1  hold fetch state and ID-side outputs.
REQ-005 Port: flush  in  1  exception or eret redirect; overrides stall and branch.
REQ-006 Port: new_pc  in  32  flush target.
REQ-007 Port: branch_flag  in  1  taken branch or jump from ID.
REQ-008 Port: branch_target  in  32  branch destination.
REQ-009 Port: rom_ce  out  1  instruction-memory chip enable, registered.
REQ-010 Port: rom_addr  out  32  byte address to instruction memory, equal to the PC register.
REQ-011 Port: rom_inst  in  32  instruction word, combinationally valid in the same cycle as rom_addr.
REQ-012 Port: id_pc  out  32  PC of the instruction handed to ID.
REQ-013 Port: id_inst  out  32  instruction handed to ID.
REQ-014 Port: id_valid  out  1  id_pc and id_inst are a real instruction, not a bubble.

Function
REQ-015 States: IDLE (rom_ce=0) and RUN (rom_ce=1); IDLE->RUN on the first clock edge after rst deasserts; RUN never returns to IDLE except through rst.
REQ-016 In IDLE: pc holds RESET_PC and the id_* outputs hold zero.
REQ-017 In RUN, when stall=0 and flush=0, on each edge: id_pc<=pc, id_inst<=rom_inst, id_valid<=1.
REQ-018 Next-pc priority: flush -> new_pc; else branch_flag with stall=0 -> branch_target; else stall=0 -> pc+4; else hold.
REQ-019 Branch with stall=0: the instruction currently at pc is still passed to ID (delay slot), and pc<=branch_target.
REQ-020 stall=1 and flush=0: pc, id_pc, id_inst and id_valid all hold; branch_flag is ignored.
REQ-021 flush=1: pc<=new_pc, id_valid<=0 and id_inst<=0 in the same edge, regardless of stall or branch_flag.
REQ-022 Flush asserted while in IDLE: the state moves to RUN and pc<=new_pc.
REQ-023 pc+4 is modulo 2^32; 32'hFFFF_FFFC wraps to 32'h0000_0000.
REQ-024 Latency: the instruction at address A appears on id_inst exactly one edge after rom_addr=A with stall=0.

Reset
REQ-025 rst=1 asynchronously forces: state=IDLE, rom_ce=0, pc=RESET_PC, id_pc=0, id_inst=0, id_valid=0 (and id_adel=0 when present).
REQ-026 rst asserted mid-operation discards any pending branch, flush or stall; after release the block restarts from RESET_PC with one IDLE cycle.

Configuration
REQ-027 With macro PC_ALIGN_CHECK_EN defined, an extra port id_adel (out, 1) is present: on an edge that would load id_valid=1 while pc[1:0]!=0, the block loads id_valid=0, id_inst=0, id_adel=1 and id_pc=pc, and otherwise loads id_adel<=0.
REQ-028 With PC_ALIGN_CHECK_EN undefined, id_adel is absent and misaligned pc is fetched normally; rom_addr low bits are passed through unchanged.

Verification
REQ-029 Reset release with RESET_PC=0 and rom returning addr>>2: rom_ce rises one edge after release; id_inst sequence 0,1,2 with id_pc 0,4,8.
REQ-030 branch_flag=1 and branch_target=0x100 while pc=0x8: id_pc sequence 0x8 (delay slot), then 0x100, 0x104.
REQ-031 stall=1 for 3 cycles at pc=0x10 with branch_flag pulsed during the stall: pc, id_* frozen for 3 cycles; branch ignored; resumes at 0x14.
REQ-032 flush=1 with new_pc=0x20 while stall=1 and branch_flag=1: next edge pc=0x20 and id_valid=0; the following edge id_pc=0x20 and id_valid=1.
REQ-033 pc forced to 0xFFFF_FFFC via flush: the next addresses are 0xFFFF_FFFC then 0x0000_0000.
REQ-034 With PC_ALIGN_CHECK_EN: flush to new_pc=0x22 -> id_adel=1, id_valid=0, id_pc=0x22; without the macro, id_valid=1.
